// File: rtl/funct_decode_queue_pkg.sv
// Opcode, ALU funct and per-lane decode-entry definitions shared by the
// ID-stage funct decoder and its ID-to-EX queue.
package funct_decode_queue_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FUNCT_NOP  = 6'h00;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam int DEC_W = 10;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       lui;
    logic       imm_zext;
    logic [5:0] funct;
  } dec_t;

  function automatic dec_t dec_mask(input dec_t d, input logic keep);
    dec_t r;
    if (keep) begin
      r = d;
    end else begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/funct_lane_decode.sv
// Combinational decode of one instruction lane into an ALU funct code
// and operand-control flags; extended opcodes are gated by EXT_ISA.
module funct_lane_decode
  import funct_decode_queue_pkg::*;
#(
  parameter int EXT_ISA = 0
) (
  input  logic       lane_valid,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  localparam logic EXT_EN = (EXT_ISA != 0);

  logic [5:0] funct_s;
  logic       zext_s;
  logic       lui_s;
  logic       illegal_s;

  // Opcode to ALU funct and flag mapping for one lane
  always_comb begin
    funct_s   = FUNCT_NOP;
    zext_s    = 1'b0;
    lui_s     = 1'b0;
    illegal_s = 1'b0;
    case (op)
      OP_SPECIAL: funct_s = funct;
      OP_LUI: begin
        funct_s = FUNCT_OR;
        lui_s   = 1'b1;
      end
      OP_ORI: begin
        funct_s = FUNCT_OR;
        zext_s  = 1'b1;
      end
      OP_JAL: funct_s = FUNCT_OR;
      OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW, OP_ADDIU: funct_s = FUNCT_ADDU;
      OP_ANDI: begin
        funct_s = FUNCT_AND;
        zext_s  = 1'b1;
      end
      OP_XORI: begin
        funct_s = FUNCT_XOR;
        zext_s  = 1'b1;
      end
      // Extended opcodes fall back to NOP + illegal when the mode is off
      OP_ADDI: begin
        funct_s   = EXT_EN ? FUNCT_ADD : FUNCT_NOP;
        illegal_s = ~EXT_EN;
      end
      OP_SLTI: begin
        funct_s   = EXT_EN ? FUNCT_SLT : FUNCT_NOP;
        illegal_s = ~EXT_EN;
      end
      OP_SLTIU: begin
        funct_s   = EXT_EN ? FUNCT_SLTU : FUNCT_NOP;
        illegal_s = ~EXT_EN;
      end
      OP_LH, OP_LHU, OP_SH: begin
        funct_s   = EXT_EN ? FUNCT_ADDU : FUNCT_NOP;
        illegal_s = ~EXT_EN;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // An absent instruction carries no funct, flags or illegal indication
  always_comb begin
    if (lane_valid) begin
      dec.valid    = 1'b1;
      dec.illegal  = illegal_s;
      dec.lui      = lui_s;
      dec.imm_zext = zext_s;
      dec.funct    = funct_s;
    end else begin
      dec = '0;
    end
  end

endmodule

// File: rtl/funct_decode_queue.sv
// LANES-wide ALU funct decoder feeding a DEPTH-entry ID-to-EX queue with
// valid/ready handshakes on both sides and a pipeline flush.
module funct_decode_queue
  import funct_decode_queue_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int DEPTH   = 2,
  parameter int EXT_ISA = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES-1:0]   in_lane_valid,
  input  logic [6*LANES-1:0] in_op,
  input  logic [6*LANES-1:0] in_funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   out_lane_valid,
  output logic [6*LANES-1:0] out_funct,
  output logic [LANES-1:0]   out_imm_zext,
  output logic [LANES-1:0]   out_lui,
  output logic [LANES-1:0]   out_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  dec_t             dec_s  [LANES];
  dec_t             head_s [LANES];
  dec_t             mem_r  [DEPTH][LANES];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    funct_lane_decode #(
      .EXT_ISA(EXT_ISA)
    ) u_lane_decode (
      .lane_valid(in_lane_valid[g]),
      .op        (in_op[6*g +: 6]),
      .funct     (in_funct[6*g +: 6]),
      .dec       (dec_s[g])
    );
  end

  // in_ready looks only at the occupancy so it never waits on EX
  assign in_ready_s  = (count_r != CNT_FULL);
  assign out_valid_s = (count_r != {CNT_W{1'b0}});
  assign push_s      = in_valid & in_ready_s;
  assign pop_s       = out_valid_s & out_ready;
  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;

  // Pointer and occupancy tracking; flush drops any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: cleared by reset, written on an accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int l = 0; l < LANES; l++) begin
          mem_r[i][l] <= '0;
        end
      end
    end else if (push_s && !flush) begin
      for (int l = 0; l < LANES; l++) begin
        mem_r[wr_ptr_r][l] <= dec_s[l];
      end
    end
  end

  // Head entry fan-out; an empty queue presents an all-zero payload
  always_comb begin
    out_lane_valid = '0;
    out_funct      = '0;
    out_imm_zext   = '0;
    out_lui        = '0;
    out_illegal    = '0;
    for (int l = 0; l < LANES; l++) begin
      head_s[l]             = dec_mask(mem_r[rd_ptr_r][l], out_valid_s);
      out_lane_valid[l]     = head_s[l].valid;
      out_funct[6*l +: 6]   = head_s[l].funct;
      out_imm_zext[l]       = head_s[l].imm_zext;
      out_lui[l]            = head_s[l].lui;
      out_illegal[l]        = head_s[l].illegal;
    end
  end

endmodule

// File: tb/tb_funct_decode_queue.sv
// Directed bench: two 2-lane, 2-deep queues (base and extended ISA) driven
// from the same stimulus; observed port bundles are compared to hand values.
module tb_funct_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  in_lane_valid;
  logic [11:0] in_op;
  logic [11:0] in_funct;

  logic        b_in_ready, b_out_valid, x_in_ready, x_out_valid;
  logic [1:0]  b_lv, b_zext, b_lui, b_ill, x_lv, x_zext, x_lui, x_ill;
  logic [11:0] b_funct, x_funct;

  int          checks = 0;
  int          errors = 0;
  logic [21:0] want;

  logic [5:0] c_op    [9] = '{6'h0C, 6'h0F, 6'h00, 6'h23, 6'h0E, 6'h09, 6'h2B, 6'h03, 6'h0D};
  logic [5:0] c_funct [9] = '{6'h24, 6'h25, 6'h27, 6'h21, 6'h26, 6'h21, 6'h21, 6'h25, 6'h25};
  logic       c_zext  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       c_lui   [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  funct_decode_queue #(.LANES(2), .DEPTH(2), .EXT_ISA(0)) u_base (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_lane_valid(in_lane_valid), .in_op(in_op), .in_funct(in_funct),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_lane_valid(b_lv),
    .out_funct(b_funct), .out_imm_zext(b_zext), .out_lui(b_lui), .out_illegal(b_ill)
  );

  funct_decode_queue #(.LANES(2), .DEPTH(2), .EXT_ISA(1)) u_ext (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(x_in_ready),
    .in_lane_valid(in_lane_valid), .in_op(in_op), .in_funct(in_funct),
    .out_valid(x_out_valid), .out_ready(out_ready), .out_lane_valid(x_lv),
    .out_funct(x_funct), .out_imm_zext(x_zext), .out_lui(x_lui), .out_illegal(x_ill)
  );

  wire [21:0] obs_b = {b_out_valid, b_in_ready, b_lv, b_funct, b_zext, b_lui, b_ill};
  wire [21:0] obs_x = {x_out_valid, x_in_ready, x_lv, x_funct, x_zext, x_lui, x_ill};

  // {out_valid, in_ready, lane_valid, funct, imm_zext, lui, illegal}
  function automatic logic [21:0] exp_vec(input logic v, input logic r, input logic [1:0] lv,
                                          input logic [11:0] f, input logic [1:0] z,
                                          input logic [1:0] u, input logic [1:0] il);
    return {v, r, lv, f, z, u, il};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [1:0] lv, input logic [11:0] op, input logic [11:0] fn);
    in_valid      = 1'b1;
    in_lane_valid = lv;
    in_op         = op;
    in_funct      = fn;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_lane_valid = 2'b00; in_op = 12'h000; in_funct = 12'h000;
    tick(); tick();
    rst = 1'b0;
    want = exp_vec(1'b0, 1'b1, 2'b00, 12'h000, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL reset_base: got %h want %h", obs_b, want); end
    checks++; if (obs_x !== want) begin errors++; $display("FAIL reset_ext: got %h want %h", obs_x, want); end
  endtask

  task automatic test_base_decode();
    out_ready = 1'b1;
    set_beat(2'b01, {6'h00, 6'h0C}, 12'h000); tick();
    want = exp_vec(1'b1, 1'b1, 2'b01, 12'h024, 2'b01, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL base_andi: got %h want %h", obs_b, want); end
    set_beat(2'b01, {6'h00, 6'h0F}, 12'h000); tick();
    want = exp_vec(1'b1, 1'b1, 2'b01, 12'h025, 2'b00, 2'b01, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL base_lui: got %h want %h", obs_b, want); end
    set_beat(2'b01, {6'h00, 6'h00}, {6'h00, 6'h2A}); tick();
    want = exp_vec(1'b1, 1'b1, 2'b01, 12'h02A, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL base_special: got %h want %h", obs_b, want); end
    in_valid = 1'b0; tick();
    want = exp_vec(1'b0, 1'b1, 2'b00, 12'h000, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL base_drain: got %h want %h", obs_b, want); end
  endtask

  task automatic test_ext_isa();
    out_ready = 1'b0;
    set_beat(2'b01, {6'h00, 6'h0A}, 12'h000); tick(); in_valid = 1'b0;
    want = exp_vec(1'b1, 1'b1, 2'b01, 12'h000, 2'b00, 2'b00, 2'b01);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL ext_slti_off: got %h want %h", obs_b, want); end
    want = exp_vec(1'b1, 1'b1, 2'b01, 12'h02A, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_x !== want) begin errors++; $display("FAIL ext_slti_on: got %h want %h", obs_x, want); end
    out_ready = 1'b1; tick();
    set_beat(2'b11, {6'h21, 6'h0A}, 12'h000); out_ready = 1'b0; tick(); in_valid = 1'b0;
    want = exp_vec(1'b1, 1'b1, 2'b11, 12'h000, 2'b00, 2'b00, 2'b11);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL ext_lh_off: got %h want %h", obs_b, want); end
    want = exp_vec(1'b1, 1'b1, 2'b11, 12'h86A, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_x !== want) begin errors++; $display("FAIL ext_lh_on: got %h want %h", obs_x, want); end
    out_ready = 1'b1; tick();
    want = exp_vec(1'b0, 1'b1, 2'b00, 12'h000, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL ext_drain_base: got %h want %h", obs_b, want); end
    checks++; if (obs_x !== want) begin errors++; $display("FAIL ext_drain_ext: got %h want %h", obs_x, want); end
  endtask

  task automatic test_multi_lane();
    out_ready = 1'b1;
    set_beat(2'b01, {6'h3F, 6'h23}, 12'h000); tick();
    want = exp_vec(1'b1, 1'b1, 2'b01, 12'h021, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL multi_lw_masked: got %h want %h", obs_b, want); end
    set_beat(2'b11, {6'h0E, 6'h3F}, 12'h000); tick();
    want = exp_vec(1'b1, 1'b1, 2'b11, 12'h980, 2'b10, 2'b00, 2'b01);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL multi_xori_illegal: got %h want %h", obs_b, want); end
    set_beat(2'b00, {6'h0C, 6'h0C}, 12'h000); tick();
    want = exp_vec(1'b1, 1'b1, 2'b00, 12'h000, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL multi_empty_beat: got %h want %h", obs_b, want); end
    in_valid = 1'b0; tick();
    want = exp_vec(1'b0, 1'b1, 2'b00, 12'h000, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL multi_drain: got %h want %h", obs_b, want); end
  endtask

  task automatic test_full_backpressure();
    out_ready = 1'b0;
    set_beat(2'b01, {6'h00, 6'h0C}, 12'h000); tick();
    set_beat(2'b01, {6'h00, 6'h0D}, 12'h000); tick();
    want = exp_vec(1'b1, 1'b0, 2'b01, 12'h024, 2'b01, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL full_after_two: got %h want %h", obs_b, want); end
    set_beat(2'b01, {6'h00, 6'h0E}, 12'h000); tick();
    checks++; if (obs_b !== want) begin errors++; $display("FAIL full_holds: got %h want %h", obs_b, want); end
    out_ready = 1'b1; tick();
    want = exp_vec(1'b1, 1'b1, 2'b01, 12'h025, 2'b01, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL full_second_beat: got %h want %h", obs_b, want); end
    tick();
    want = exp_vec(1'b1, 1'b1, 2'b01, 12'h026, 2'b01, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL full_third_beat: got %h want %h", obs_b, want); end
    in_valid = 1'b0; tick();
    want = exp_vec(1'b0, 1'b1, 2'b00, 12'h000, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL full_drain: got %h want %h", obs_b, want); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_beat(2'b01, {6'h00, c_op[0]}, {6'h00, 6'h27}); tick();
    want = exp_vec(1'b1, 1'b1, 2'b01, {6'h00, c_funct[0]}, {1'b0, c_zext[0]}, {1'b0, c_lui[0]}, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL b2b_prime: got %h want %h", obs_b, want); end
    out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      set_beat(2'b01, {6'h00, c_op[i]}, {6'h00, 6'h27}); tick();
      want = exp_vec(1'b1, 1'b1, 2'b01, {6'h00, c_funct[i]}, {1'b0, c_zext[i]}, {1'b0, c_lui[i]}, 2'b00);
      checks++; if (obs_b !== want) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, obs_b, want); end
    end
    in_valid = 1'b0; tick();
    want = exp_vec(1'b0, 1'b1, 2'b00, 12'h000, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL b2b_drain: got %h want %h", obs_b, want); end
  endtask

  task automatic test_clear(input logic use_rst, input int n);
    out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      set_beat(2'b01, {6'h00, 6'h0D}, 12'h000); tick();
    end
    set_beat(2'b01, {6'h00, 6'h0E}, 12'h000);
    out_ready = 1'b1; rst = use_rst; flush = ~use_rst;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    want = exp_vec(1'b0, 1'b1, 2'b00, 12'h000, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL clear_rst%0d_n%0d_empty: got %h want %h", use_rst, n, obs_b, want); end
    tick();
    checks++; if (obs_b !== want) begin errors++; $display("FAIL clear_rst%0d_n%0d_nobeat: got %h want %h", use_rst, n, obs_b, want); end
    out_ready = 1'b0;
    set_beat(2'b01, {6'h00, 6'h09}, 12'h000); tick(); in_valid = 1'b0;
    want = exp_vec(1'b1, 1'b1, 2'b01, 12'h021, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL clear_rst%0d_n%0d_restart: got %h want %h", use_rst, n, obs_b, want); end
    out_ready = 1'b1; tick();
    want = exp_vec(1'b0, 1'b1, 2'b00, 12'h000, 2'b00, 2'b00, 2'b00);
    checks++; if (obs_b !== want) begin errors++; $display("FAIL clear_rst%0d_n%0d_drain: got %h want %h", use_rst, n, obs_b, want); end
  endtask

  initial begin
    test_reset();
    test_base_decode();
    test_ext_isa();
    test_multi_lane();
    test_full_backpressure();
    test_back_to_back();
    test_clear(1'b0, 2);
    test_clear(1'b1, 2);
    test_clear(1'b0, 1);
    test_clear(1'b1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/funct_decode_queue.md
Name: funct_decode_queue

Overview:
- Parametrised successor to the ID-stage ALU funct generator.
- Decodes LANES instructions per beat (op plus funct field) into ALU funct codes and operand-control flags.
- Results are buffered in a DEPTH-entry queue between ID and EX, with valid/ready handshake on both sides and a pipeline flush.
- Optional extended-ISA decode mode adds opcodes beyond the base set.

Parameters:
- LANES, 1: instructions decoded per beat; all lanes of a beat move together.
- DEPTH, 2: queue entries; power of two, at least 2.
- EXT_ISA, 0: 1 enables decode of ADDI, SLTI, SLTIU, LH, LHU, SH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous queue clear (branch/exception)
- in_valid  in  1  beat offered by ID
- in_ready  out  1  queue can accept a beat
- in_lane_valid  in  LANES  per-lane instruction present
- in_op  in  6*LANES  opcode per lane; lane 0 in the LSBs
- in_funct  in  6*LANES  instruction funct field per lane
- out_valid  out  1  head beat available to EX
- out_ready  in  1  EX consumes the head beat
- out_lane_valid  out  LANES  head per-lane valid
- out_funct  out  6*LANES  ALU funct per lane
- out_imm_zext  out  LANES  immediate is zero-extended (ANDI/ORI/XORI)
- out_lui  out  LANES  immediate is shifted left by 16
- out_illegal  out  LANES  unrecognised opcode on a valid lane

Behaviour:
Decode (combinational, per lane, before the queue):
- SPECIAL (0x00): in_funct passes through.
- LUI (0x0F), ORI (0x0D), JAL (0x03): OR (0x25).
- LB (0x20), LBU (0x24), LW (0x23), SB (0x28), SW (0x2B), ADDIU (0x09): ADDU (0x21).
- ANDI (0x0C): AND (0x24). XORI (0x0E): XOR (0x26).
- When EXT_ISA=1, additionally:
  - ADDI (0x08): ADD (0x20).
  - SLTI (0x0A): SLT (0x2A).
  - SLTIU (0x0B): SLTU (0x2B).
  - LH (0x21), LHU (0x25), SH (0x29): ADDU.
- Any other opcode: funct = NOP (0x00) and illegal = in_lane_valid for that lane.
- Flags:
  - imm_zext = 1 for ANDI/ORI/XORI.
  - lui = 1 for LUI.
  - For invalid lanes, all flags, illegal and funct are 0.

Queue:
- Circular buffer with write pointer, read pointer and count of log2(DEPTH)+1 bits.
- Each entry stores the lane-valid bits, decoded functs and flags.
- in_ready = (count != DEPTH). It is combinational from count only and must not depend on out_ready.
- push = in_valid & in_ready. pop = out_valid & out_ready. out_valid = (count != 0).
- Outputs are driven from the entry at the read pointer. With count 0, all out_* payloads are 0.
- Latency: a beat pushed in cycle N is visible at the outputs in cycle N+1 (minimum one cycle).
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any count below DEPTH.
- Full (count = DEPTH): in_ready=0, so no push is possible. A pop that cycle makes in_ready=1 in the next cycle.
- Pointers wrap modulo DEPTH.
- in_valid=1 with in_lane_valid=0 is a legal empty beat and is queued normally.

Reset and flush:
- rst (highest priority): pointers, count and all stored entries clear; out_valid=0, in_ready=1 in the next cycle.
- flush: same effect as rst on pointers and count. Any same-cycle push and pop are discarded. The stored payload need not clear, but outputs still read as 0 because count=0.
- rst or flush mid-stream: in-flight beats are lost and no partial beat is ever emitted.

Decomposition:
- Shared package/header (extend the existing opcode and funct include files): the OP_ADDI, OP_SLTI, OP_SLTIU, OP_LH, OP_LHU, OP_SH codes and the FUNCT_ADD, FUNCT_SLT, FUNCT_SLTU codes. Also a decode-entry width constant of 10 bits per lane (funct 6 + zext + lui + illegal + valid).
- One natural sub-module, funct_lane_decode: combinational decode of one lane, with EXT_ISA passed through. It is instantiated LANES times via generate.

Test Plan:
- Base decode: LANES=1, push op=0x0C, then 0x0F, then 0x00/funct 0x2A. Expect out_funct 0x24 (zext=1), then 0x25 (lui=1), then 0x2A, each one cycle after push.
- EXT_ISA: EXT_ISA=0, op=0x0A gives illegal=1, funct 0x00. EXT_ISA=1, op=0x0A gives funct 0x2A, illegal=0.
- Multi-lane: LANES=2, lane_valid=2'b01, ops {0x23, 0x3F}. Expect out_funct lane0=0x21, lane1=0x00, illegal=2'b00.
- Full and backpressure: DEPTH=2, out_ready=0, offer 3 beats. in_ready drops after 2 pushes. Raise out_ready: beats emerge in order, and the third is accepted the cycle after the first pop.
- Concurrent push/pop: count=1, push and pop every cycle for 8 cycles. count stays 1, order is preserved and pointers wrap.
- Flush/reset: 2 entries queued, assert flush with in_valid=1. Next cycle out_valid=0, in_ready=1, and the flush-cycle beat never appears. Repeat with rst for the same result.
